// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, FSM encodings and opcode classification helpers for the
// memory-access stage.
package mem_access_unit_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store-side enables and replication, load-side
// lane extraction with sign or zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            st_op,
    input  logic [1:0]            st_off,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [3:0]            st_be,
    output logic [DATA_WIDTH-1:0] st_wdata,
    input  logic [3:0]            ld_op,
    input  logic [1:0]            ld_off,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [7:0]  lanes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = ld_rdata[8*gi +: 8];
            // Loads and full-word stores enable every lane.
            assign st_be[gi] = (st_op == MEM_SB) ? (st_off == 2'(gi)) :
                               (st_op == MEM_SH) ? (st_off[1] == (gi >= 2)) :
                               1'b1;
        end
    endgenerate

    always_comb begin
        st_wdata = st_data;
        case (st_op)
            MEM_SB:  st_wdata = {4{st_data[7:0]}};
            MEM_SH:  st_wdata = {2{st_data[15:0]}};
            default: st_wdata = st_data;
        endcase
    end

    always_comb begin
        sel_byte = lanes[ld_off];
        sel_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data  = ld_rdata;
        case (ld_op)
            MEM_LB:  ld_data = {{24{sel_byte[7]}}, sel_byte};
            MEM_LBU: ld_data = {24'd0, sel_byte};
            MEM_LH:  ld_data = {{16{sel_half[15]}}, sel_half};
            MEM_LHU: ld_data = {16'd0, sel_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store responder: request/grant bus master with
// read-valid return, pipeline stall, misalignment and bus-timeout errors.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_we_i,
    input  logic [4:0]            reg_waddr_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    output logic                  stall_o,
    output logic                  ld_valid_o,
    output logic [DATA_WIDTH-1:0] ld_data_o,
    output logic [4:0]            ld_waddr_o,
    output logic                  err_misalign_o,
    output logic                  err_bus_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_reg, state_next;
    logic [3:0]            op_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [3:0]            be_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  we_reg;
    logic [4:0]            rd_reg;
    logic [1:0]            off_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  err_mis_reg;
    logic                  err_bus_reg;
    logic                  ld_ok_reg;
    logic [DATA_WIDTH-1:0] ld_data_reg;
    logic [4:0]            ld_waddr_reg;

    logic                  valid_op;
    logic                  legal_op;
    logic                  reject_op;
    logic                  timed_out;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] ld_ext;

    mem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lane_align (
        .st_op    (mem_op_i),
        .st_off   (mem_addr_i[1:0]),
        .st_data  (mem_data_i),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_op    (op_reg),
        .ld_off   (off_reg),
        .ld_rdata (bus_rdata_i),
        .ld_data  (ld_ext)
    );

    // A we flag that disagrees with the opcode class is rejected like a misalignment.
    assign valid_op  = (mem_op_i != MEM_NOP);
    assign legal_op  = (is_load(mem_op_i) && !mem_we_i) || (is_store(mem_op_i) && mem_we_i);
    assign reject_op = !legal_op || is_misaligned(mem_op_i, mem_addr_i[1:0]);
    assign timed_out = (cnt_reg == CNT_MAX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (valid_op) begin
                    state_next = reject_op ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_gnt_i) begin
                    state_next = we_reg ? ST_DONE : ST_WAIT;
                end else if (timed_out) begin
                    state_next = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid_i || timed_out) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg    <= ST_IDLE;
            op_reg       <= MEM_NOP;
            addr_reg     <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
            rd_reg       <= '0;
            off_reg      <= '0;
            cnt_reg      <= '0;
            err_mis_reg  <= 1'b0;
            err_bus_reg  <= 1'b0;
            ld_ok_reg    <= 1'b0;
            ld_data_reg  <= '0;
            ld_waddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (valid_op) begin
                        if (reject_op) begin
                            err_mis_reg <= 1'b1;
                        end else begin
                            op_reg    <= mem_op_i;
                            addr_reg  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            be_reg    <= st_be;
                            wdata_reg <= st_wdata;
                            we_reg    <= mem_we_i;
                            rd_reg    <= reg_waddr_i;
                            off_reg   <= mem_addr_i[1:0];
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_gnt_i) begin
                        cnt_reg <= '0;
                    end else if (timed_out) begin
                        err_bus_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid_i) begin
                        ld_data_reg  <= ld_ext;
                        ld_waddr_reg <= rd_reg;
                        ld_ok_reg    <= 1'b1;
                    end else if (timed_out) begin
                        err_bus_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    err_mis_reg <= 1'b0;
                    err_bus_reg <= 1'b0;
                    ld_ok_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req_o      = (state_reg == ST_REQ);
    assign bus_we_o       = we_reg;
    assign bus_addr_o     = addr_reg;
    assign bus_be_o       = be_reg;
    assign bus_wdata_o    = wdata_reg;
    assign stall_o        = ((state_reg != ST_IDLE) && (state_reg != ST_DONE)) ||
                            ((state_reg == ST_IDLE) && valid_op);
    assign ld_valid_o     = ld_ok_reg;
    assign ld_data_o      = ld_data_reg;
    assign ld_waddr_o     = ld_waddr_reg;
    assign err_misalign_o = err_mis_reg;
    assign err_bus_o      = err_bus_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, extended loads, misalignment,
// delayed handshakes, timeout and reset-abort scenarios.
module tb_mem_access_unit;

    localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                           OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                           OP_SW = 4'd8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  mem_op = OP_NOP;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        mem_we = 1'b0;
    logic [4:0]  reg_waddr = '0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall, ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_waddr;
    logic        err_misalign, err_bus;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .mem_op_i       (mem_op),
        .mem_addr_i     (mem_addr),
        .mem_data_i     (mem_data),
        .mem_we_i       (mem_we),
        .reg_waddr_i    (reg_waddr),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_addr_o     (bus_addr),
        .bus_be_o       (bus_be),
        .bus_wdata_o    (bus_wdata),
        .bus_gnt_i      (bus_gnt),
        .bus_rvalid_i   (bus_rvalid),
        .bus_rdata_i    (bus_rdata),
        .stall_o        (stall),
        .ld_valid_o     (ld_valid),
        .ld_data_o      (ld_data),
        .ld_waddr_o     (ld_waddr),
        .err_misalign_o (err_misalign),
        .err_bus_o      (err_bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one load with a responsive slave; gnt after gnt_wait REQ cycles,
    // rvalid in the rv_wait-th WAIT cycle.
    task automatic drive_load(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                              input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                              output logic [31:0] data_obs, output int valid_cnt,
                              output int req_cycles, output int done_step,
                              output bit addr_stable, output bit stall_ok);
        logic [31:0] first_addr;
        bit granted;
        bit done;
        int wait_cycles;
        valid_cnt = 0; req_cycles = 0; done_step = -1; addr_stable = 1; stall_ok = 1;
        granted = 0; done = 0; wait_cycles = 0; data_obs = '0; first_addr = '0;
        mem_op = op; mem_addr = addr; mem_we = 1'b0; reg_waddr = rd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdata;
        #1;
        if (!stall) stall_ok = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            tick();
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            if (ld_valid) begin
                valid_cnt++;
                data_obs = ld_data;
                done_step = cyc;
                if (stall) stall_ok = 0;
                done = 1;
            end else if (err_bus || err_misalign) begin
                done = 1;
            end else begin
                if (!stall) stall_ok = 0;
                if (bus_req) begin
                    req_cycles++;
                    if (req_cycles == 1) first_addr = bus_addr;
                    else if (bus_addr !== first_addr) addr_stable = 0;
                    if (req_cycles > gnt_wait) begin
                        bus_gnt = 1'b1;
                        granted = 1;
                    end
                end else if (granted) begin
                    wait_cycles++;
                    if (wait_cycles >= rv_wait) bus_rvalid = 1'b1;
                end
            end
        end
        mem_op = OP_NOP;
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        tick();
        if (ld_valid) valid_cnt++;
        $display("load op=%0d addr=%h rdata=%h -> data=%h valids=%0d req_cycles=%0d done_step=%0d",
                 op, addr, rdata, data_obs, valid_cnt, req_cycles, done_step);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        mem_op = OP_NOP;
        tick();
        tick();
        n_checks++;
        if ({bus_req, bus_we, stall, ld_valid, err_misalign, err_bus} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req/we/stall/ldv/emis/ebus=%b required 000000",
                     {bus_req, bus_we, stall, ld_valid, err_misalign, err_bus});
        end
        n_checks++;
        if ({bus_addr, bus_be, bus_wdata, ld_data, ld_waddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h be=%b wdata=%h ld_data=%h ld_waddr=%0d required all 0",
                     bus_addr, bus_be, bus_wdata, ld_data, ld_waddr);
        end
        rst_i = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_store();
        logic [3:0]  ops   [3] = '{OP_SB, OP_SH, OP_SW};
        logic [31:0] addrs [3] = '{32'h0000_1003, 32'h0000_1002, 32'h0000_1004};
        logic [31:0] datas [3] = '{32'h0000_00A5, 32'h1234_BEEF, 32'hDEAD_BEEF};
        logic [31:0] exp_a [3] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004};
        logic [3:0]  exp_be[3] = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] exp_w [3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hDEAD_BEEF};
        for (int i = 0; i < 3; i++) begin
            mem_op = ops[i]; mem_addr = addrs[i]; mem_data = datas[i]; mem_we = 1'b1;
            bus_gnt = 1'b1;
            #1;
            n_checks++;
            if ({stall, bus_req} !== 2'b10) begin
                n_fail++;
                $display("FAIL store_idle[%0d]: got stall/req=%b required 10", i, {stall, bus_req});
            end
            tick();
            n_checks++;
            if ({bus_req, bus_we, stall, bus_addr, bus_be, bus_wdata} !==
                {3'b111, exp_a[i], exp_be[i], exp_w[i]}) begin
                n_fail++;
                $display("FAIL store_req[%0d]: got req/we/stall=%b addr=%h be=%b wdata=%h required 111 %h %b %h",
                         i, {bus_req, bus_we, stall}, bus_addr, bus_be, bus_wdata,
                         exp_a[i], exp_be[i], exp_w[i]);
            end
            tick();
            n_checks++;
            if ({stall, ld_valid, bus_req, err_misalign, err_bus} !== 5'b0) begin
                n_fail++;
                $display("FAIL store_done[%0d]: got stall/ldv/req/emis/ebus=%b required 00000",
                         i, {stall, ld_valid, bus_req, err_misalign, err_bus});
            end
            mem_op = OP_NOP; mem_we = 1'b0; bus_gnt = 1'b0;
            tick();
            $display("store op=%0d addr=%h data=%h -> bus_addr=%h be=%b wdata=%h",
                     ops[i], addrs[i], datas[i], bus_addr, bus_be, bus_wdata);
        end
    endtask

    task automatic test_loads();
        logic [3:0]  ops   [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        logic [31:0] addrs [5] = '{32'h2001, 32'h2001, 32'h3002, 32'h3002, 32'h3004};
        logic [31:0] rdat  [5] = '{32'h1234_80FF, 32'h1234_80FF, 32'h8001_0000,
                                   32'h8001_0000, 32'hCAFE_F00D};
        logic [31:0] exp_d [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                   32'h0000_8001, 32'hCAFE_F00D};
        logic [31:0] d;
        int vc, rc, ds;
        bit as, so;
        for (int i = 0; i < 5; i++) begin
            drive_load(ops[i], addrs[i], 5'(i + 3), 0, 1, rdat[i], d, vc, rc, ds, as, so);
            n_checks++;
            if (d !== exp_d[i] || vc != 1) begin
                n_fail++;
                $display("FAIL load_data[%0d]: got data=%h valids=%0d required data=%h valids=1",
                         i, d, vc, exp_d[i]);
            end
            n_checks++;
            if (ds != 3 || rc != 1 || !so) begin
                n_fail++;
                $display("FAIL load_latency[%0d]: got done_step=%0d req_cycles=%0d stall_ok=%0d required 3 1 1",
                         i, ds, rc, so);
            end
            n_checks++;
            if (ld_data !== exp_d[i] || ld_waddr !== 5'(i + 3) || ld_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_hold[%0d]: got ld_data=%h ld_waddr=%0d ldv=%b required %h %0d 0",
                         i, ld_data, ld_waddr, ld_valid, exp_d[i], i + 3);
            end
        end
    endtask

    task automatic test_misalign();
        logic [3:0]  ops   [3] = '{OP_LW, OP_LH, OP_SW};
        logic [31:0] addrs [3] = '{32'h3002, 32'h3001, 32'h3000};
        logic        wes   [3] = '{1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            mem_op = ops[i]; mem_addr = addrs[i]; mem_we = wes[i];
            #1;
            n_checks++;
            if ({stall, bus_req} !== 2'b10) begin
                n_fail++;
                $display("FAIL misalign_idle[%0d]: got stall/req=%b required 10", i, {stall, bus_req});
            end
            tick();
            n_checks++;
            if ({err_misalign, err_bus, bus_req, ld_valid, stall} !== 5'b10000) begin
                n_fail++;
                $display("FAIL misalign_done[%0d]: got emis/ebus/req/ldv/stall=%b required 10000",
                         i, {err_misalign, err_bus, bus_req, ld_valid, stall});
            end
            mem_op = OP_NOP;
            tick();
            n_checks++;
            if ({err_misalign, bus_req, stall} !== 3'b000) begin
                n_fail++;
                $display("FAIL misalign_after[%0d]: got emis/req/stall=%b required 000",
                         i, {err_misalign, bus_req, stall});
            end
            $display("reject op=%0d addr=%h we=%b", ops[i], addrs[i], wes[i]);
        end
    endtask

    task automatic test_delayed_handshake();
        logic [31:0] d;
        int vc, rc, ds;
        bit as, so;
        drive_load(OP_LW, 32'h0000_6008, 5'd9, 5, 3, 32'h0BAD_CAFE, d, vc, rc, ds, as, so);
        n_checks++;
        if (rc != 6 || !as) begin
            n_fail++;
            $display("FAIL delayed_req: got req_cycles=%0d addr_stable=%0d required 6 1", rc, as);
        end
        n_checks++;
        if (!so || ds != 10) begin
            n_fail++;
            $display("FAIL delayed_stall: got stall_ok=%0d done_step=%0d required 1 10", so, ds);
        end
        n_checks++;
        if (d !== 32'h0BAD_CAFE || vc != 1) begin
            n_fail++;
            $display("FAIL delayed_data: got data=%h valids=%0d required 0badcafe 1", d, vc);
        end
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        int err_step = -1;
        mem_op = OP_SW; mem_addr = 32'h0000_4000; mem_data = 32'h1111_2222; mem_we = 1'b1;
        bus_gnt = 1'b0;
        for (int cyc = 1; cyc <= 30 && err_step < 0; cyc++) begin
            tick();
            if (err_bus) begin
                err_step = cyc;
                n_checks++;
                if ({bus_req, stall, ld_valid} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL timeout_done: got req/stall/ldv=%b required 000",
                             {bus_req, stall, ld_valid});
                end
            end else if (bus_req) begin
                req_cnt++;
            end
        end
        n_checks++;
        if (req_cnt != 8 || err_step != 9) begin
            n_fail++;
            $display("FAIL timeout_count: got req_cycles=%0d err_step=%0d required 8 9", req_cnt, err_step);
        end
        mem_op = OP_NOP; mem_we = 1'b0;
        tick();
        n_checks++;
        if ({err_bus, bus_req, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_idle: got ebus/req/stall=%b required 000", {err_bus, bus_req, stall});
        end
        $display("timeout store addr=4000 req_cycles=%0d err_step=%0d", req_cnt, err_step);
    endtask

    task automatic test_reset_in_wait();
        int ldv_seen = 0;
        mem_op = OP_LW; mem_addr = 32'h0000_5000; mem_we = 1'b0; reg_waddr = 5'd7;
        bus_gnt = 1'b0;
        #1;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        n_checks++;
        if ({bus_req, stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstwait_wait: got req/stall=%b required 01", {bus_req, stall});
        end
        rst_i = 1'b0;
        mem_op = OP_NOP;
        tick();
        rst_i = 1'b1;
        bus_rdata = 32'h7777_7777;
        bus_rvalid = 1'b1;
        tick();
        bus_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ld_valid) ldv_seen++;
            tick();
        end
        n_checks++;
        if (ldv_seen != 0 || ld_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_ldv: got ld_valid pulses=%0d required 0", ldv_seen);
        end
        n_checks++;
        if ({bus_req, stall, err_misalign, err_bus, bus_addr, bus_be, ld_data, ld_waddr} !== '0) begin
            n_fail++;
            $display("FAIL rstwait_outputs: got req=%b stall=%b addr=%h be=%b ld_data=%h ld_waddr=%0d required all 0",
                     bus_req, stall, bus_addr, bus_be, ld_data, ld_waddr);
        end
        $display("reset during wait, late rvalid ignored");
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_misalign();
        test_delayed_handshake();
        test_timeout();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage responder for the load/store requests produced by the execute stage: consumes mem_op/addr/data/we.
- Drives a word-wide data-RAM bus with a request/grant plus read-valid handshake, and generates byte enables and lane replication.
- Returns sign- or zero-extended load data to writeback.
- Stalls the pipeline through pipe_ctrl while an access is in flight, and flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- TIMEOUT_CYCLES, 256, cycles waited in REQ or WAIT before a bus error is declared.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- mem_op_i  in  4  MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW
- mem_addr_i  in  ADDR_WIDTH  byte address
- mem_data_i  in  DATA_WIDTH  store data, taken from the low bits
- mem_we_i  in  1  store indication; must agree with mem_op_i
- reg_waddr_i  in  5  load destination register
- bus_req_o  out  1  request valid
- bus_we_o  out  1  write
- bus_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  DATA_WIDTH  lane-replicated write data
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  DATA_WIDTH  read data
- stall_o  out  1  hold upstream stages
- ld_valid_o  out  1  one-cycle load completion
- ld_data_o  out  DATA_WIDTH  extended load data
- ld_waddr_o  out  5  load destination register
- err_misalign_o  out  1  one-cycle pulse
- err_bus_o  out  1  one-cycle pulse

Behaviour:
- **Reset (rst_i = 0 at a clock edge):**
  - State goes to IDLE.
  - All outputs are 0, bus_addr_o = 0, counter = 0.
  - Reset in any state aborts the access and drops bus_req_o the next cycle.
  - A bus_rvalid_i arriving after reset is ignored.
- **Valid op:** mem_op_i != MEM_NOP. It is illegal if mem_we_i disagrees with the op class (store ops vs load ops); an illegal op is treated as misaligned.
- **stall_o:** = (state != IDLE && state != DONE) || (state == IDLE && valid op). Combinational from inputs in IDLE only.
- **IDLE:**
  - Valid aligned op: register op, word address, be, wdata, rd and byte offset; go to REQ.
  - Misaligned op (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0) or illegal op: go to DONE with err_misalign flagged. No bus activity.
  - MEM_NOP: stay in IDLE.
- **REQ:**
  - bus_req_o = 1; address, we, be and wdata are stable while waiting.
  - bus_gnt_i = 1: store goes to DONE; load goes to WAIT; counter cleared.
- **WAIT:**
  - bus_req_o = 0.
  - bus_rvalid_i = 1: capture bus_rdata_i and go to DONE.
  - bus_rvalid_i is sampled only in WAIT. The slave contract is at least one cycle after grant.
- **Timeout:** in REQ or WAIT the counter increments every cycle. When it reaches TIMEOUT_CYCLES-1 without the exit event, go to DONE with err_bus flagged and drop bus_req_o.
- **DONE (exactly one cycle):**
  - stall_o = 0; mem_op_i is ignored because the upstream is still presenting the completed op.
  - ld_valid_o = 1 only for a successful load.
  - err_* pulse as flagged.
  - Next state is IDLE.
- **Byte lanes (off = addr[1:0]):**
  - SB: be = 1 << off; wdata = {4{data[7:0]}}.
  - SH: be = off[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - SW: be = 1111; wdata = data.
  - Loads: be = 1111.
- **Load extraction:**
  - LB/LBU take byte off; LH/LHU take halfword off[1].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - LW returns the word as read.
- **ld_data_o / ld_waddr_o:** hold their last value when ld_valid_o = 0.
- **Minimum latency:**
  - Load with immediate grant and rvalid the next cycle: 4 cycles (IDLE, REQ, WAIT, DONE).
  - Store: 3 cycles.

Decomposition:
- defines.v gets:
  - MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW as 4'd0..4'd8;
  - the state encodings IDLE/REQ/WAIT/DONE as 2-bit values.
- One combinational sub-module, mem_lane_align:
  - store direction: op + offset + data -> be/wdata;
  - load direction: op + offset + rdata -> extended data.
- The FSM and counter stay in the top module.

Test Plan:
- SB addr 0x1003, data 0x000000A5, gnt in the first REQ cycle -> bus_be_o = 1000, bus_wdata_o = 0xA5A5A5A5, bus_addr_o = 0x1000; stall high 2 cycles then low in DONE; no ld_valid_o.
- LB addr 0x2001, rdata 0x1234_80FF, rdata byte 1 = 0x80 -> ld_data_o = 0xFFFFFF80, ld_valid_o for 1 cycle. Same access as LBU -> 0x00000080.
- LH addr 0x3002, rdata 0x8001_0000 -> ld_data_o = 0xFFFF8001. LW addr 0x3002 -> err_misalign_o pulse, no bus_req_o, ld_valid_o = 0.
- Load with bus_gnt_i delayed 5 cycles and rvalid 3 cycles later -> bus_req_o held with stable address for 6 cycles; stall_o continuous until DONE.
- TIMEOUT_CYCLES = 8 with gnt never asserted -> err_bus_o pulse after 8 REQ cycles, bus_req_o drops, back in IDLE.
- rst_i low during WAIT, then rvalid pulses after release -> IDLE, all outputs 0, no ld_valid_o.
